// File: rtl/coarse_tune_pkg.sv
// coarse_tune_pkg
// Shared definitions for the coarse DCO tuning controller: FSM state
// encoding, default timing/width parameters and the coarse code width.
package coarse_tune_pkg;

  // Default parameter values used by coarse_tune_ctrl.
  localparam int unsigned WIN_CYCLES_DEF    = 256;
  localparam int unsigned SETTLE_CYCLES_DEF = 16;
  localparam int unsigned CNT_W_DEF         = 10;

  // The DCO coarse control code is 7 bits wide.
  localparam int unsigned COARSE_W = 7;

  // FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SETTLE  = 3'd1;
  localparam state_t ST_MEASURE = 3'd2;
  localparam state_t ST_DECIDE  = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  // Code loaded when a run starts: only the MSB set, the first trial.
  localparam logic [COARSE_W-1:0] FIRST_TRIAL = 7'b1000000;

endpackage

// File: rtl/coarse_tune_ctrl_edge_sync.sv
// edge_sync
// Brings the asynchronous DCO output into the ref_clk domain through a
// 2-flop synchronizer and produces a registered one-cycle pulse per rising
// edge.
// Ports:
//   clk_i   - ref_clk
//   rst_ni  - asynchronous active-low reset
//   async_i - asynchronous input (dco_out)
//   rise_o  - one-cycle pulse per synchronized rising edge
module edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  // Synchronizer chain, previous-value flop and registered edge pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/coarse_tune_ctrl.sv
// coarse_tune_ctrl
// Successive-approximation search of the 7-bit DCO coarse code. For each
// bit (MSB first) the trial code is applied, the DCO is allowed to settle,
// its rising edges are counted over a fixed window and the bit is dropped
// when the count exceeds the target.
// Ports:
//   ref_clk      - sole clock
//   reset_       - asynchronous active-low reset
//   dco_out      - DCO output, asynchronous to ref_clk
//   start        - one-cycle pulse starting a run (ignored while busy)
//   target_count - desired edges per window, captured on accepted start
//   coarse       - DCO coarse code
//   busy         - high while a run is in progress
//   done         - one-cycle pulse at run completion
//   meas_count   - edge count of the most recent completed window
module coarse_tune_ctrl
  import coarse_tune_pkg::*;
#(
  parameter int unsigned WIN_CYCLES    = WIN_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic                ref_clk,
  input  logic                reset_,
  input  logic                dco_out,
  input  logic                start,
  input  logic [CNT_W-1:0]    target_count,
  output logic [COARSE_W-1:0] coarse,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    meas_count
);

  // One timer serves both SETTLE and MEASURE, so size it for the longer.
  localparam int unsigned TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LAST = TMR_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t               state_q,  state_d;
  logic [COARSE_W-1:0]  coarse_q, coarse_d;
  logic [2:0]           idx_q,    idx_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic [CNT_W-1:0]     meas_q,   meas_d;
  logic [CNT_W-1:0]     target_q, target_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [TMR_W-1:0]     tmr_q,    tmr_d;
  logic                 rise_s;

  edge_sync u_edge_sync (
    .clk_i   (ref_clk),
    .rst_ni  (reset_),
    .async_i (dco_out),
    .rise_o  (rise_s)
  );

  // Next-state logic for the search FSM and its datapath.
  always_comb begin
    state_d  = state_q;
    coarse_d = coarse_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    meas_d   = meas_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d = target_count;
          coarse_d = FIRST_TRIAL;
          idx_d    = 3'd6;
          tmr_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_SETTLE;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        // Edges seen while settling are discarded by clearing on exit.
        if (tmr_q == SET_LAST) begin
          tmr_d   = '0;
          cnt_d   = '0;
          state_d = ST_MEASURE;
        end else begin
          tmr_d   = tmr_q + TMR_W'(1);
        end
      end
      ST_MEASURE: begin
        if (rise_s && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
        if (tmr_q == WIN_LAST) begin
          tmr_d   = '0;
          state_d = ST_DECIDE;
        end else begin
          tmr_d   = tmr_q + TMR_W'(1);
        end
      end
      ST_DECIDE: begin
        meas_d = cnt_q;
        // A DCO running fast means the trial bit overshoots; equality keeps it.
        if (cnt_q > target_q) begin
          coarse_d[idx_q] = 1'b0;
        end else begin
          coarse_d[idx_q] = coarse_q[idx_q];
        end
        if (idx_q != 3'd0) begin
          coarse_d[idx_q - 3'd1] = 1'b1;
          idx_d   = idx_q - 3'd1;
          state_d = ST_SETTLE;
        end else begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge ref_clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= ST_IDLE;
      coarse_q <= '0;
      idx_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      meas_q   <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      coarse_q <= coarse_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      meas_q   <= meas_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
    end
  end

  assign coarse     = coarse_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign meas_count = meas_q;

endmodule

// File: tb/tb_coarse_tune_ctrl.sv
// Self-checking bench for coarse_tune_ctrl. The DCO is a phase accumulator
// adding the current coarse code every ref_clk cycle and emitting a
// one-cycle pulse on each wrap of 256, so any 256 consecutive cycles at a
// fixed code hold exactly `code` rising edges.
module tb_coarse_tune_ctrl;

  localparam int W        = 256;
  localparam int S        = 16;
  localparam int CW       = 10;
  localparam int BIT_LAT  = S + W + 1;
  localparam int RUN_LAT  = 7 * BIT_LAT + 2;

  logic          ref_clk = 1'b0;
  logic          reset_  = 1'b0;
  logic          dco_out = 1'b0;
  logic          start   = 1'b0;
  logic [CW-1:0] target_count = '0;
  logic [6:0]    coarse;
  logic          busy;
  logic          done;
  logic [CW-1:0] meas_count;

  coarse_tune_ctrl #(.WIN_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(CW)) dut (
    .ref_clk      (ref_clk),
    .reset_       (reset_),
    .dco_out      (dco_out),
    .start        (start),
    .target_count (target_count),
    .coarse       (coarse),
    .busy         (busy),
    .done         (done),
    .meas_count   (meas_count)
  );

  always #5 ref_clk = ~ref_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // DCO model
  int acc    = 0;
  bit dco_en = 1'b1;
  always @(negedge ref_clk) begin
    acc = acc + int'(coarse);
    if (acc >= 256) begin
      acc     = acc - 256;
      dco_out = dco_en;
    end else begin
      dco_out = 1'b0;
    end
  end

  // Behavioural model of a run: trial codes, per-trial counts, result.
  bit model_on   = 1'b0;
  bit run_active = 1'b0;
  bit pending    = 1'b0;
  int ofs        = 0;
  int trial[7];
  int meas_exp[7];
  int final_code  = 0;
  int idle_coarse = 0;
  int idle_meas   = 0;

  function automatic int edges_for(input int code);
    return dco_en ? code : 0;
  endfunction

  task automatic plan(input int tgt);
    int code;
    code = 0;
    for (int k = 0; k < 7; k++) begin
      trial[k]    = code | (64 >> k);
      meas_exp[k] = edges_for(trial[k]);
      if (meas_exp[k] <= tgt) code = trial[k];
    end
    final_code = code;
  endtask

  // Model time base: offset in cycles since the accepted start edge.
  always @(posedge ref_clk) begin
    if (pending && start && reset_) begin
      run_active = 1'b1;
      ofs        = 0;
      pending    = 1'b0;
    end else if (run_active) begin
      ofs++;
      if (ofs == 7 * BIT_LAT + 1) begin
        run_active  = 1'b0;
        idle_coarse = final_code;
        idle_meas   = meas_exp[6];
      end
    end
  end

  // Cycle-by-cycle compare against the model.
  always @(negedge ref_clk) begin
    int ec, em, eb, ed, b;
    if (model_on) begin
      if (run_active) begin
        if (ofs < 7 * BIT_LAT) begin
          b  = ofs / BIT_LAT;
          ec = trial[b];
          em = (b == 0) ? idle_meas : meas_exp[b-1];
          eb = 1;
          ed = 0;
        end else begin
          ec = final_code;
          em = meas_exp[6];
          eb = 1;
          ed = 1;
        end
      end else begin
        ec = idle_coarse;
        em = idle_meas;
        eb = 0;
        ed = 0;
      end
      check("cyc_coarse", int'(coarse), ec);
      check("cyc_meas",   int'(meas_count), em);
      check("cyc_busy",   int'(busy), eb);
      check("cyc_done",   int'(done), ed);
    end
  end

  int done_cnt = 0;
  always @(negedge ref_clk) if (done === 1'b1) done_cnt++;

  task automatic do_run(input int tgt, input bit repulse, input int exp_c,
                        input int exp_m, input string nm);
    int cyc;
    bit seen;
    @(negedge ref_clk);
    plan(tgt);
    check({nm, "_model_code"}, final_code, exp_c);
    check({nm, "_model_meas"}, meas_exp[6], exp_m);
    done_cnt     = 0;
    target_count = CW'(tgt);
    start        = 1'b1;
    pending      = 1'b1;
    cyc          = 1;
    seen         = 1'b0;
    while (!seen && cyc < RUN_LAT + 200) begin
      @(negedge ref_clk);
      cyc++;
      start = (repulse && cyc == 100);
      if (cyc == 2) target_count = ~CW'(tgt);
      if (done === 1'b1) seen = 1'b1;
    end
    check({nm, "_latency"}, seen ? cyc : -1, 1913);
    repeat (3) @(negedge ref_clk);
    check({nm, "_coarse"}, int'(coarse), exp_c);
    check({nm, "_meas"}, int'(meas_count), exp_m);
    check({nm, "_done_pulses"}, done_cnt, 1);
    check({nm, "_busy_low"}, int'(busy), 0);
  endtask

  initial begin
    reset_ = 1'b0;
    repeat (3) @(negedge ref_clk);
    #1;
    check("rst_coarse", int'(coarse), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_meas", int'(meas_count), 0);
    @(negedge ref_clk);
    reset_   = 1'b1;
    model_on = 1'b1;
    repeat (3) @(negedge ref_clk);

    do_run(77,  1'b0, 77,  77,  "t77");
    do_run(0,   1'b0, 0,   1,   "t0");
    do_run(200, 1'b0, 127, 127, "t200");
    @(negedge ref_clk);
    dco_en = 1'b0;
    do_run(5,   1'b0, 127, 0,   "tied_low");
    @(negedge ref_clk);
    dco_en = 1'b1;
    do_run(64,  1'b0, 64,  65,  "t64");
    do_run(100, 1'b1, 100, 101, "repulse");

    // Reset during SETTLE aborts the run without a done pulse.
    @(negedge ref_clk);
    plan(77);
    done_cnt     = 0;
    target_count = CW'(77);
    start        = 1'b1;
    pending      = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    repeat (5) @(negedge ref_clk);
    check("pre_abort_busy", int'(busy), 1);
    #2;
    model_on    = 1'b0;
    reset_      = 1'b0;
    run_active  = 1'b0;
    pending     = 1'b0;
    idle_coarse = 0;
    idle_meas   = 0;
    #1;
    check("abort_coarse", int'(coarse), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_meas", int'(meas_count), 0);
    check("abort_done", int'(done), 0);
    repeat (3) @(negedge ref_clk);
    reset_   = 1'b1;
    model_on = 1'b1;
    repeat (600) @(negedge ref_clk);
    check("abort_no_done", done_cnt, 0);
    check("abort_idle_busy", int'(busy), 0);
    check("abort_idle_coarse", int'(coarse), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/coarse_tune_ctrl.md
COARSE_TUNE_CTRL -- requirements
Module: coarse_tune_ctrl

Interface
REQ-001 SHALL have parameter WIN_CYCLES, default 256: measurement window length in ref_clk cycles.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16: wait in ref_clk cycles after each coarse code change.
REQ-003 SHALL have parameter CNT_W, default 10: width of the DCO edge counter and of target_count.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, exactly as follows.
REQ-005 ref_clk  input  1  sole clock; its frequency is at least 4x the maximum dco_out frequency.
REQ-006 reset_  input  1  asynchronous active-low reset.
REQ-007 dco_out  input  1  DCO output, asynchronous to ref_clk.
REQ-008 start  input  1  one-cycle pulse that begins a tuning run.
REQ-009 target_count  input  CNT_W  desired dco_out rising edges per window; sampled on accepted start.
REQ-010 coarse  output  7  DCO coarse control code.
REQ-011 busy  output  1  high while a run is in progress.
REQ-012 done  output  1  one-cycle pulse when a run completes.
REQ-013 meas_count  output  CNT_W  edge count of the most recent completed window.

Function
REQ-014 DCO frequency increases monotonically with coarse; the block performs a 7-step MSB-first successive-approximation search.
REQ-015 States SHALL be IDLE, SETTLE, MEASURE, DECIDE and DONE.
REQ-016 IDLE: start=1 -> latch target_count, set coarse=7'b1000000 and bit index=6, go to SETTLE; busy rises the next cycle.
REQ-017 SETTLE: count SETTLE_CYCLES ref_clk cycles, then clear the edge counter and go to MEASURE; edges during SETTLE are ignored.
REQ-018 MEASURE: for exactly WIN_CYCLES cycles, increment the edge counter on each synchronized dco_out rising edge; the counter saturates at all-ones.
REQ-019 DECIDE (1 cycle): load meas_count with the counter value; if count > target, clear coarse[idx]; count == target or count < target keeps the bit.
REQ-020 DECIDE, idx>0: set coarse[idx-1]=1, decrement idx, go to SETTLE.
REQ-021 DECIDE, idx==0: go to DONE.
REQ-022 DONE (1 cycle): done=1, then IDLE with busy=0; coarse holds the result until the next start.
REQ-023 Per-bit latency is SETTLE_CYCLES+WIN_CYCLES+1; total start-to-done latency is 7x that plus 2 cycles.
REQ-024 start while busy SHALL be ignored; target_count changes mid-run SHALL have no effect.
REQ-025 Edge detection uses 2-flop synchronization plus rising-edge compare; a dco_out held static produces count 0.

Reset
REQ-026 reset_ low SHALL asynchronously force: state=IDLE, coarse=0, busy=0, done=0, meas_count=0, all counters and synchronizer flops=0.
REQ-027 Reset asserted mid-run SHALL abort the run with no done pulse; after release the block waits in IDLE for start.

Structure
REQ-028 Shared package coarse_tune_pkg SHALL hold the state enumeration, default WIN_CYCLES/SETTLE_CYCLES/CNT_W, and coarse width 7.
REQ-029 Sub-module edge_sync SHALL implement the synchronizer and rising-edge detector; everything else stays in coarse_tune_ctrl.

Verification
REQ-030 The bench DCO model SHALL produce exactly coarse rising edges per 256-cycle window, with settling inside SETTLE_CYCLES.
REQ-031 Scenario: target=77, start -> done after 7x273+2 cycles, coarse=77, meas_count=77.
REQ-032 Scenario: target=0 -> coarse=0; target=200 -> coarse=127 (every bit kept).
REQ-033 Scenario: dco_out tied low, target=5 -> every bit kept, coarse=127, meas_count=0.
REQ-034 Scenario: start re-pulsed during MEASURE -> ignored, with exactly one done pulse; reset_ low mid-SETTLE -> coarse=0 and busy=0 immediately, with no done pulse.
REQ-035 Scenario: target=64 with a model yielding 64 edges at code 64 -> bit 6 kept on equality, final coarse=64.
